conv_out_quant: RTL

Output requantisation stage placed directly after the 3x3 adder tree. It accepts the adder tree's final 36-bit signed accumulation, one pixel per cycle, and adds a per-channel bias. It then applies ReLU, performs a rounding arithmetic right shift and saturates the result to 8 bits for write-back to feature-map memory. It is a 3-stage pipeline with a valid/ready handshake, an output pixel/tile counter and a saturation-event counter.

---
 rtl/conv_out_quant.sv | 125 ++++++++++++
 1 files changed

// File: rtl/conv_out_quant.sv
// conv_out_quant: bias add, optional ReLU, rounding right shift and 8-bit saturation after the 3x3 adder tree.
// Build option ACT_RELU_EN: defined gives ReLU with unsigned 0..255 output, undefined gives signed -128..127.
module conv_out_quant #(
  parameter int PIX_CNT = 196,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [35:0] in_sum,
  input  logic signed [15:0] bias,
  input  logic        [4:0]  q_shift,
  output logic               out_valid,
  input  logic               out_ready,
  output logic        [7:0]  out_data,
  output logic               out_last,
  output logic        [15:0] sat_cnt,
  output logic               idle
);
  localparam int DATA_W = 36;
  localparam int COEF_W = 16;
  localparam int ACC_W  = DATA_W + 1;
  localparam int RND_W  = DATA_W + 2;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIX_CNT - 1);

  // Negative values are zeroed before rounding so they never register as clamps.
  function automatic logic signed [RND_W-1:0] round_shift(input logic signed [ACC_W-1:0] a,
                                                          input logic [4:0] sh);
    logic signed [RND_W-1:0] x;
    logic signed [RND_W-1:0] half;
    x = {a[ACC_W-1], a};
`ifdef ACT_RELU_EN
    if (a[ACC_W-1]) x = '0;
`endif
    half = '0;
    if (sh != 5'd0) begin
      half = 38'sd1 <<< (sh - 5'd1);
      x = (x + half) >>> sh;
    end
    return x;
  endfunction

  // Returns {clamp_flag, value}.
  function automatic logic [8:0] sat8(input logic signed [RND_W-1:0] v);
    logic signed [RND_W-1:0] hi;
    logic signed [RND_W-1:0] lo;
`ifdef ACT_RELU_EN
    hi = 38'sd255;
    lo = 38'sd0;
`else
    hi = 38'sd127;
    lo = -38'sd128;
`endif
    if (v > hi) return {1'b1, hi[7:0]};
    if (v < lo) return {1'b1, lo[7:0]};
    return {1'b0, v[7:0]};
  endfunction

  logic                    vld_p0, vld_p1, vld_p2;
  logic signed [ACC_W-1:0] acc_p0;
  logic signed [RND_W-1:0] rnd_p1;
  logic                    sat_p2;
  logic [CNT_W-1:0]        pcnt;
  logic                    en;
  logic                    fire;
  logic [8:0]              sat_res;
  logic signed [ACC_W-1:0] sum_ext;
  logic signed [ACC_W-1:0] bias_ext;

  assign en       = !vld_p2 || out_ready;
  assign fire     = vld_p2 && out_ready;
  assign in_ready = en;
  assign sum_ext  = {in_sum[DATA_W-1], in_sum};
  assign bias_ext = {{(ACC_W-COEF_W){bias[COEF_W-1]}}, bias};
  assign sat_res  = sat8(rnd_p1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (en) begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // stage p0: exact 37-bit bias add
  always_ff @(posedge clk) begin
    if (en && in_valid) acc_p0 <= sum_ext + bias_ext;
  end

  // stage p1: activation and round-half-up shift
  always_ff @(posedge clk) begin
    if (en && vld_p0) rnd_p1 <= round_shift(acc_p0, q_shift);
  end

  // stage p2: saturated output register, cleared by reset so out_data reads 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      sat_p2   <= 1'b0;
    end else if (en && vld_p1) begin
      out_data <= sat_res[7:0];
      sat_p2   <= sat_res[8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
      pcnt    <= '0;
    end else if (fire) begin
      if (sat_p2 && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
      pcnt <= (pcnt == LAST_PIX) ? '0 : pcnt + 1'b1;
    end
  end

  assign out_valid = vld_p2;
  assign out_last  = vld_p2 && (pcnt == LAST_PIX);
  assign idle      = !(vld_p0 || vld_p1 || vld_p2);

endmodule
